// File: rtl/mem_pkg.sv
// mem_pkg: shared FSM state type and default geometry for the clearable single-port memory.
package mem_pkg;
    typedef enum logic {CLEAR, IDLE} state_e;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 7;
    localparam int DEF_DEPTH  = 128;
endpackage

// File: rtl/mem_be_merge.sv
// mem_be_merge: replaces the byte lanes of old_word selected by be with the matching wdata bytes.
module mem_be_merge
    import mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W-1:0]   old_word,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] be,
    output logic [DATA_W-1:0]   merged
);
    for (genvar k = 0; k < DATA_W / 8; k++) begin : g_lane
        assign merged[8*k +: 8] = be[k] ? wdata[8*k +: 8] : old_word[8*k +: 8];
    end
endmodule

// File: rtl/mem_sp_clr.sv
// mem_sp_clr: single-port byte-enabled memory that zeroes itself after reset and on clr_req,
// with one-cycle read latency and an error pulse for out-of-range accesses.
module mem_sp_clr
    import mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] be,
    input  logic                wr_en,
    input  logic                rd_en,
    input  logic                clr_req,
    output logic [DATA_W-1:0]   rdata,
    output logic                rvalid,
    output logic                ready,
    output logic                err
);
    logic [DATA_W-1:0] mem [DEPTH];
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              err_q, err_d;
    logic              in_range;
    logic [DATA_W-1:0] old_word, merged;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wval;

    assign in_range = 32'(addr) < 32'(DEPTH);
    assign old_word = in_range ? mem[addr] : '0;
    assign ready    = state_q == IDLE;

    mem_be_merge #(.DATA_W(DATA_W)) u_merge (
        .old_word(old_word),
        .wdata   (wdata),
        .be      (be),
        .merged  (merged)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        err_d    = 1'b0;
        mem_we   = 1'b0;
        mem_addr = addr;
        mem_wval = merged;
        if (state_q == CLEAR) begin
            mem_we   = 1'b1;
            mem_addr = ptr_q;
            mem_wval = '0;
            ptr_d    = ptr_q == ADDR_W'(DEPTH - 1) ? '0 : ptr_q + 1'b1;
            state_d  = ptr_q == ADDR_W'(DEPTH - 1) ? IDLE : CLEAR;
        end else if (clr_req) begin
            state_d = CLEAR;
            ptr_d   = '0;
        end else begin
            // old_word is sampled before the write lands, so read-during-write returns old data
            rvalid_d = rd_en;
            err_d    = (wr_en | rd_en) & ~in_range;
            mem_we   = wr_en & in_range;
            rdata_d  = rd_en ? old_word : rdata_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= CLEAR;
            ptr_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
        end
    end

    // Storage is deliberately unreset; the sweep zeroes it instead.
    always_ff @(posedge clk) begin
        if (rst && mem_we) mem[mem_addr] <= mem_wval;
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign err    = err_q;
endmodule

// File: tb/tb_mem_sp_clr.sv
// tb_mem_sp_clr: drives two instances (8-bit/128 words and 32-bit/100 words) with directed
// vectors, checking every cycle against a word-array model plus literal expectations.
module tb_mem_sp_clr;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [6:0]  addr    [2];
    logic [31:0] wdata   [2];
    logic [3:0]  be      [2];
    logic        wr_en   [2];
    logic        rd_en   [2];
    logic        clr_req [2];
    logic [7:0]  rdata_a;
    logic [31:0] rdata_b;
    logic        rvalid_a, rvalid_b, ready_a, ready_b, err_a, err_b;

    mem_sp_clr u_a (
        .clk(clk), .rst(rst), .addr(addr[0]), .wdata(wdata[0][7:0]), .be(be[0][0:0]),
        .wr_en(wr_en[0]), .rd_en(rd_en[0]), .clr_req(clr_req[0]),
        .rdata(rdata_a), .rvalid(rvalid_a), .ready(ready_a), .err(err_a)
    );

    mem_sp_clr #(.DATA_W(32), .ADDR_W(7), .DEPTH(100)) u_b (
        .clk(clk), .rst(rst), .addr(addr[1]), .wdata(wdata[1]), .be(be[1]),
        .wr_en(wr_en[1]), .rd_en(rd_en[1]), .clr_req(clr_req[1]),
        .rdata(rdata_b), .rvalid(rvalid_b), .ready(ready_b), .err(err_b)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: word arrays, cycles of clearing still owed, and the expected output registers.
    bit [31:0]   mm [2][128];
    int          cnt [2];
    logic [31:0] e_rd [2];
    logic        e_rv [2];
    logic        e_er [2];
    int          dep [2]   = '{128, 100};
    bit [3:0]    lanes [2] = '{4'h1, 4'hF};

    function automatic void model_step(input int i);
        bit ok;
        if (!rst) begin
            cnt[i] = dep[i];
            e_rd[i] = '0;
            e_rv[i] = 1'b0;
            e_er[i] = 1'b0;
            return;
        end
        e_rv[i] = 1'b0;
        e_er[i] = 1'b0;
        if (cnt[i] > 0) begin
            mm[i][dep[i] - cnt[i]] = '0;
            cnt[i]--;
        end else if (clr_req[i]) begin
            cnt[i] = dep[i];
        end else if (wr_en[i] || rd_en[i]) begin
            ok = int'(addr[i]) < dep[i];
            e_er[i] = !ok;
            if (rd_en[i]) begin
                e_rv[i] = 1'b1;
                e_rd[i] = ok ? mm[i][addr[i]] : 32'h0;
            end
            if (wr_en[i] && ok)
                for (int k = 0; k < 4; k++)
                    if (be[i][k] && lanes[i][k]) mm[i][addr[i]][8*k +: 8] = wdata[i][8*k +: 8];
        end
    endfunction

    always begin
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        chk("a_rdata",  {24'h0, rdata_a}, e_rd[0]);
        chk("a_rvalid", rvalid_a, e_rv[0]);
        chk("a_err",    err_a,    e_er[0]);
        chk("a_ready",  ready_a,  rst && cnt[0] == 0);
        chk("b_rdata",  rdata_b,  e_rd[1]);
        chk("b_rvalid", rvalid_b, e_rv[1]);
        chk("b_err",    err_b,    e_er[1]);
        chk("b_ready",  ready_b,  rst && cnt[1] == 0);
    end

    task automatic op(input int i, input bit w, input bit r, input bit c,
                      input logic [6:0] a, input logic [31:0] d, input logic [3:0] b);
        @(negedge clk);
        wr_en[i] = w; rd_en[i] = r; clr_req[i] = c;
        addr[i] = a; wdata[i] = d; be[i] = b;
        @(negedge clk);
        wr_en[i] = 1'b0; rd_en[i] = 1'b0; clr_req[i] = 1'b0;
    endtask

    task automatic lit(input int i, input string n, input logic rv, input logic er, input logic [31:0] rd);
        chk({n, "_rvalid"}, i == 0 ? rvalid_a : rvalid_b, rv);
        chk({n, "_err"},    i == 0 ? err_a : err_b, er);
        chk({n, "_rdata"},  i == 0 ? {24'h0, rdata_a} : rdata_b, rd);
    endtask

    task automatic wait_rel(input int ea, input int eb);
        int na = 0;
        int nb = 0;
        for (int n = 1; n <= 400 && (na == 0 || nb == 0); n++) begin
            @(negedge clk);
            if (ready_a && na == 0) na = n;
            if (ready_b && nb == 0) nb = n;
        end
        chk("a_ready_cycles", na, ea);
        chk("b_ready_cycles", nb, eb);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            addr[i] = '0; wdata[i] = '0; be[i] = '0;
            wr_en[i] = 1'b0; rd_en[i] = 1'b0; clr_req[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        wait_rel(128, 100);
        op(0, 0, 1, 0, 7'd127, 0, 0);                lit(0, "a_init_read", 1, 0, 32'h0);
        op(1, 0, 1, 0, 7'd99, 0, 0);                 lit(1, "b_init_read", 1, 0, 32'h0);
        op(0, 1, 0, 0, 7'd5, 32'hA5, 4'h1);
        op(0, 0, 1, 0, 7'd5, 0, 0);                  lit(0, "a_read5", 1, 0, 32'hA5);
        @(negedge clk);                              lit(0, "a_hold", 0, 0, 32'hA5);
        op(0, 1, 0, 0, 7'd5, 32'hFF, 4'h0);          lit(0, "a_be0", 0, 0, 32'hA5);
        op(0, 0, 1, 0, 7'd5, 0, 0);                  lit(0, "a_be0_read", 1, 0, 32'hA5);
        op(0, 1, 0, 0, 7'd9, 32'h77, 4'h1);
        op(0, 1, 1, 0, 7'd9, 32'h3C, 4'h1);          lit(0, "a_rdw_old", 1, 0, 32'h77);
        op(0, 0, 1, 0, 7'd9, 0, 0);                  lit(0, "a_rdw_new", 1, 0, 32'h3C);
        op(1, 1, 0, 0, 7'd3, 32'h11223344, 4'hF);
        op(1, 1, 0, 0, 7'd3, 32'hAABBCCDD, 4'h5);
        op(1, 0, 1, 0, 7'd3, 0, 0);                  lit(1, "b_merge", 1, 0, 32'h11BB33DD);
        op(1, 1, 0, 0, 7'd120, 32'hFFFFFFFF, 4'hF);  lit(1, "b_oor_wr", 0, 1, 32'h11BB33DD);
        op(1, 0, 1, 0, 7'd120, 0, 0);                lit(1, "b_oor_rd", 1, 1, 32'h0);
        op(1, 0, 1, 0, 7'd3, 0, 0);                  lit(1, "b_after_oor", 1, 0, 32'h11BB33DD);
        op(1, 0, 1, 0, 7'd20, 0, 0);                 lit(1, "b_alias20", 1, 0, 32'h0);
        op(1, 0, 0, 1, 7'd0, 0, 0);
        chk("b_clr_ready", ready_b, 1'b0);
        repeat (20) @(negedge clk);
        op(1, 1, 0, 0, 7'd5, 32'hCAFEF00D, 4'hF);    lit(1, "b_ignored_wr", 0, 0, 32'h0);
        for (int n = 0; n < 200 && !ready_b; n++) @(negedge clk);
        chk("b_ready_after_clr", ready_b, 1'b1);
        op(1, 0, 1, 0, 7'd5, 0, 0);                  lit(1, "b_ignored_rd", 1, 0, 32'h0);
        op(1, 0, 1, 0, 7'd3, 0, 0);                  lit(1, "b_cleared3", 1, 0, 32'h0);
        op(0, 1, 0, 1, 7'd5, 32'h11, 4'h1);
        repeat (39) @(negedge clk);
        chk("a_mid_clear_ready", ready_a, 1'b0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        lit(0, "a_in_reset", 0, 0, 32'h0);
        chk("a_in_reset_ready", ready_a, 1'b0);
        rst = 1'b1;
        wait_rel(128, 100);
        for (int a = 0; a < 128; a++) begin
            op(0, 0, 1, 0, 7'(a), 0, 0);
            lit(0, "a_sweep", 1, 0, 32'h0);
        end
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_sp_clr.md
MEM_SP_CLR -- requirements
Module: mem_sp_clr

Interface
REQ-001 Parameters SHALL be, one per line:
- DATA_W, 8, data width in bits; multiple of 8.
- ADDR_W, 7, address width in bits.
- DEPTH, 128, number of words; 1 <= DEPTH <= 2**ADDR_W.
REQ-002 Ports SHALL be, one per line:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-low (asserted at 0).
- addr  input  ADDR_W  word address.
- wdata  input  DATA_W  write data.
- be  input  DATA_W/8  byte enables; bit k selects wdata[8k+7:8k].
- wr_en  input  1  write request.
- rd_en  input  1  read request.
- clr_req  input  1  start a full-array clear; single-cycle pulse.
- rdata  output  DATA_W  read data.
- rvalid  output  1  rdata valid, one-cycle pulse.
- ready  output  1  block accepts wr_en/rd_en this cycle.
- err  output  1  one-cycle pulse on an out-of-range access.

Function
REQ-003 Storage SHALL be DEPTH words of DATA_W bits; the array itself SHALL NOT be reset by rst.
REQ-004 The FSM SHALL have states CLEAR and IDLE; after rst deasserts, the state SHALL be CLEAR with clear pointer 0.
REQ-005 In CLEAR, each cycle SHALL write 0 to word[ptr] and increment ptr; after the write to DEPTH-1 the state SHALL go to IDLE on the next edge (DEPTH cycles total).
REQ-006 ready SHALL be 1 only in IDLE; wr_en, rd_en and clr_req SHALL be ignored while ready=0.
REQ-007 In IDLE, clr_req=1 SHALL move the state to CLEAR with ptr=0; a wr_en/rd_en in the same cycle SHALL be dropped.
REQ-008 A write (ready & wr_en & addr<DEPTH) SHALL update only the bytes whose be bit is 1, at the clock edge.
REQ-009 A read (ready & rd_en & addr<DEPTH) SHALL present word[addr] on rdata with rvalid=1 exactly one cycle later (latency 1).
REQ-010 rdata SHALL hold its last value when rvalid=0.
REQ-011 With wr_en and rd_en both set on the same valid address, the read SHALL return the pre-write (old) data, and the write SHALL still occur.
REQ-012 An accepted access with addr>=DEPTH SHALL pulse err=1 one cycle later, SHALL NOT modify storage, and for a read SHALL give rvalid=1 with rdata=0.
REQ-013 be=0 with wr_en=1 SHALL be a legal no-op write with no err.

Reset
REQ-014 While rst=0, outputs SHALL be: rdata=0, rvalid=0, err=0, ready=0; state SHALL be CLEAR with ptr=0.
REQ-015 rst asserted mid-CLEAR or mid-access SHALL abort the operation immediately, and the sweep SHALL restart from address 0 after release.

Structure
REQ-016 A shared package mem_pkg SHALL hold the state enum (CLEAR, IDLE) and the default DATA_W, ADDR_W and DEPTH constants.
REQ-017 The byte-lane write-merge logic SHALL be one sub-module, mem_be_merge (old word, wdata, be -> merged word), instantiated once.
REQ-018 The implementation SHALL be a single clocked process for the FSM/outputs and one for the array, with no latches.

Verification
REQ-019 Reset release: ready SHALL stay 0 for 128 cycles and then go to 1; a read of any address SHALL then return 0x00 with rvalid.
REQ-020 Write 0xA5 to address 5 with be=1, then read address 5: rvalid SHALL pulse one cycle after the read with rdata=0xA5.
REQ-021 DATA_W=32: write 0x11223344 with be=0xF, then 0xAABBCCDD with be=0x5, then read: result SHALL be 0x11BB33DD.
REQ-022 Simultaneous write 0x3C and read at address 9 holding 0x77: rdata SHALL be 0x77, and a later read SHALL return 0x3C.
REQ-023 DEPTH=100: write to address 120 SHALL pulse err with storage unchanged; read of address 120 SHALL pulse err and rvalid with rdata=0.
REQ-024 Pulse clr_req after writes, then assert rst at clear cycle 40: ready SHALL return only 128 cycles after release, and all words SHALL read 0.
